// File: rtl/dota_trim_seq.sv
// Offset-calibration sequencer for the digital OTA: successive-approximation search
// of the trim word driven by a synchronised, majority-voted comparator output.
module dota_trim_seq #(
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int SAMPLES    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              cmp_in,
    input  logic              trim_load,
    input  logic [TRIM_W-1:0] trim_in,
    output logic              ota_en,
    output logic              cal_mode,
    output logic [TRIM_W-1:0] trim,
    output logic              busy,
    output logic              done
);

    localparam int BIT_W   = $clog2(TRIM_W);
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLES) ? SETTLE_CYC : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int ONES_W  = $clog2(SAMPLES + 1);

    localparam logic [TRIM_W-1:0] MID         = {1'b1, {(TRIM_W-1){1'b0}}};
    localparam logic [BIT_W-1:0]  TOP_BIT     = BIT_W'(TRIM_W - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLES - 1);
    localparam logic [ONES_W-1:0] HALF        = ONES_W'(SAMPLES / 2);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DECIDE,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [BIT_W-1:0]   bit_idx, bit_idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ONES_W-1:0]  ones, ones_n;
    logic [TRIM_W-1:0]  trim_n;
    logic               ota_en_n, cal_mode_n, busy_n, done_n;
    logic               cmp_meta, cmp_sync;

    // cmp_in is asynchronous to clk; only cmp_sync is ever used by the search
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta <= 1'b0;
            cmp_sync <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_sync <= cmp_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_idx  <= TOP_BIT;
            cnt      <= '0;
            ones     <= '0;
            trim     <= MID;
            ota_en   <= 1'b0;
            cal_mode <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_idx  <= bit_idx_n;
            cnt      <= cnt_n;
            ones     <= ones_n;
            trim     <= trim_n;
            ota_en   <= ota_en_n;
            cal_mode <= cal_mode_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    // All outputs are computed here as next-state values so they leave as flops
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        cnt_n      = cnt;
        ones_n     = ones;
        trim_n     = trim;
        ota_en_n   = ota_en;
        cal_mode_n = cal_mode;
        busy_n     = busy;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = SETTLE;
                    trim_n     = MID;
                    bit_idx_n  = TOP_BIT;
                    cnt_n      = '0;
                    ones_n     = '0;
                    ota_en_n   = 1'b1;
                    cal_mode_n = 1'b1;
                    busy_n     = 1'b1;
                end else if (trim_load) begin
                    trim_n = trim_in;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                ones_n = ones + ONES_W'(cmp_sync);
                if (cnt == SAMPLE_LAST) begin
                    cnt_n   = '0;
                    state_n = DECIDE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DECIDE: begin
                // A majority-high comparator means the trim is too high: drop this bit
                if (ones > HALF) begin
                    trim_n[bit_idx] = 1'b0;
                end
                if (bit_idx != '0) begin
                    trim_n[bit_idx - BIT_W'(1)] = 1'b1;
                    bit_idx_n = bit_idx - BIT_W'(1);
                    cnt_n     = '0;
                    ones_n    = '0;
                    state_n   = SETTLE;
                end else begin
                    state_n    = DONE;
                    done_n     = 1'b1;
                    cal_mode_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // abort overrides every transition out of a busy state, DONE included
        if (abort && (state != IDLE)) begin
            state_n    = IDLE;
            trim_n     = MID;
            bit_idx_n  = TOP_BIT;
            cnt_n      = '0;
            ones_n     = '0;
            ota_en_n   = 1'b0;
            cal_mode_n = 1'b0;
            busy_n     = 1'b0;
            done_n     = 1'b0;
        end
    end

endmodule

// File: tb/tb_dota_trim_seq.sv
// Scoreboard bench for dota_trim_seq: runs are queued with a model-predicted result
// and done-edge; a monitor pops and compares whenever done is presented.
module tb_dota_trim_seq;

    localparam int TRIM_W     = 6;
    localparam int SETTLE_CYC = 16;
    localparam int SAMPLES    = 5;
    localparam int PER_BIT    = SETTLE_CYC + SAMPLES + 1;

    localparam int M_TIE0  = 0;
    localparam int M_TIE1  = 1;
    localparam int M_THR   = 2;
    localparam int M_NOISE = 3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              cmp_in;
    logic              trim_load;
    logic [TRIM_W-1:0] trim_in;
    logic              ota_en;
    logic              cal_mode;
    logic [TRIM_W-1:0] trim;
    logic              busy;
    logic              done;

    typedef struct {
        logic [TRIM_W-1:0] trim;
        int                done_edge;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks;
    int failures;
    int edge_cnt;
    int run_k;
    int cmp_mode;
    int thr;
    int n_high;
    int skew;

    dota_trim_seq #(
        .TRIM_W    (TRIM_W),
        .SETTLE_CYC(SETTLE_CYC),
        .SAMPLES   (SAMPLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .cmp_in   (cmp_in),
        .trim_load(trim_load),
        .trim_in  (trim_in),
        .ota_en   (ota_en),
        .cal_mode (cal_mode),
        .trim     (trim),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Result = largest code whose majority comparator vote is 0
    function automatic logic [TRIM_W-1:0] ref_result(input int m, input int t, input int nh);
        for (int c = (1 << TRIM_W) - 1; c >= 0; c--) begin
            logic maj_hi;
            case (m)
                M_TIE0:  maj_hi = 1'b0;
                M_TIE1:  maj_hi = 1'b1;
                M_THR:   maj_hi = (c > t);
                default: maj_hi = (nh > SAMPLES / 2);
            endcase
            if (!maj_hi) return TRIM_W'(c);
        end
        return '0;
    endfunction

    // Comparator model with random sub-half-cycle skew; noise mode places n_high
    // highs inside the window the synchroniser feeds into each bit's samples
    always @(negedge clk) begin
        int r;
        skew = $urandom_range(0, 4);
        #(skew);
        r = edge_cnt + 1 - run_k;
        case (cmp_mode)
            M_TIE0:  cmp_in = 1'b0;
            M_TIE1:  cmp_in = 1'b1;
            M_THR:   cmp_in = (int'(trim) > thr);
            default: cmp_in = (r >= 0) && ((r % PER_BIT) >= SETTLE_CYC - 1)
                              && ((r % PER_BIT) < SETTLE_CYC - 1 + n_high);
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at edge %0d", name, act, exp_v, edge_cnt);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL spurious_done actual=1 expected=0 at edge %0d", edge_cnt);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("done_trim", 32'(trim), 32'(mon_e.trim));
                checkOutput("done_edge", edge_cnt, mon_e.done_edge);
                checkOutput("done_cal_mode", 32'(cal_mode), 0);
                checkOutput("done_ota_en", 32'(ota_en), 1);
                checkOutput("done_busy", 32'(busy), 1);
            end
        end
    end

    task automatic applyStimulus(input int m, input int t, input int nh, input logic with_load);
        @(negedge clk);
        cmp_mode  = m;
        thr       = t;
        n_high    = nh;
        start     = 1'b1;
        trim_load = with_load;
        trim_in   = 6'h0A;
        run_k     = edge_cnt + 1;
        sb_q.push_back('{ref_result(m, t, nh), run_k + TRIM_W * PER_BIT});
        @(negedge clk);
        start     = 1'b0;
        trim_load = 1'b0;
    endtask

    task automatic waitEdge(input int target);
        for (int i = 0; i < 400 && edge_cnt < target; i++) @(negedge clk);
        if (edge_cnt < target) begin
            checks++;
            failures++;
            $display("[TB] FAIL wait_edge actual=%0d expected=%0d", edge_cnt, target);
        end
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        edge_cnt  = 0;
        run_k     = 0;
        cmp_mode  = M_TIE0;
        thr       = 0;
        n_high    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        trim_load = 1'b0;
        trim_in   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_trim", 32'(trim), 32);
        checkOutput("rst_ota_en", 32'(ota_en), 0);
        checkOutput("rst_cal_mode", 32'(cal_mode), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        trim_in   = 6'h15;
        trim_load = 1'b1;
        @(negedge clk);
        trim_load = 1'b0;
        checkOutput("load_idle", 32'(trim), 21);

        // start together with trim_load: start wins, then busy-time start/load ignored
        applyStimulus(M_TIE0, 0, 0, 1'b1);
        checkOutput("start_trim_mid", 32'(trim), 32);
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_cal_mode", 32'(cal_mode), 1);
        checkOutput("start_ota_en", 32'(ota_en), 1);
        waitEdge(run_k + 30);
        start     = 1'b1;
        trim_load = 1'b1;
        trim_in   = 6'h0A;
        @(negedge clk);
        start     = 1'b0;
        trim_load = 1'b0;
        checkOutput("busy_load_ignored", 32'(trim), 48);
        waitDrain();
        checkOutput("post_done_pulse", 32'(done), 0);
        checkOutput("post_busy", 32'(busy), 0);
        checkOutput("post_ota_en", 32'(ota_en), 1);
        checkOutput("post_trim", 32'(trim), 63);

        applyStimulus(M_TIE1, 0, 0, 1'b0);
        for (int b = 0; b < TRIM_W; b++) begin
            waitEdge(run_k + b * PER_BIT + 1);
            checkOutput("tie1_step_trim", 32'(trim), 32 >> b);
        end
        waitDrain();

        applyStimulus(M_NOISE, 0, 2, 1'b0);
        waitDrain();
        applyStimulus(M_NOISE, 0, 3, 1'b0);
        waitDrain();

        applyStimulus(M_THR, 37, 0, 1'b0);
        waitDrain();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(M_THR, int'($urandom_range(0, 63)), 0, 1'b0);
            waitDrain();
        end

        applyStimulus(M_TIE0, 0, 0, 1'b0);
        waitEdge(run_k + 39);
        abort = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_trim", 32'(trim), 32);
        checkOutput("abort_ota_en", 32'(ota_en), 0);
        checkOutput("abort_cal_mode", 32'(cal_mode), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        repeat (30) @(negedge clk);
        applyStimulus(M_THR, int'($urandom_range(0, 63)), 0, 1'b0);
        waitDrain();

        applyStimulus(M_THR, int'($urandom_range(0, 63)), 0, 1'b0);
        waitEdge(run_k + 18);
        #2;
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        checkOutput("async_rst_trim", 32'(trim), 32);
        checkOutput("async_rst_ota_en", 32'(ota_en), 0);
        checkOutput("async_rst_cal_mode", 32'(cal_mode), 0);
        checkOutput("async_rst_busy", 32'(busy), 0);
        checkOutput("async_rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(M_THR, int'($urandom_range(0, 63)), 0, 1'b0);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
